sr_cmd_driver: RTL and testbench

- Upstream command stage for the SR latch.
- Accepts set/clear requests over a valid/ready handshake and drives S/R pulses of programmable width.
- Guarantees S and R are never asserted together, so the latch never sees the forbidden S=R=1 input.
- After each pulse, checks the latch's Q output fed back on q_fb and reports done or err per command.

---
 rtl/sr_cmd_driver.sv | 120 ++++++++++++
 tb/tb_sr_cmd_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
// Command stage for an SR latch: turns accepted set/clear requests into S/R pulses,
// then watches q_fb for the target value and reports done or err.
module sr_cmd_driver #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1,
   parameter int TIMEOUT = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_set,
   output logic             req_ready,
   output logic             S,
   output logic             R,
   input  logic             q_fb,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
   localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             tgt_q, tgt_d;
   logic             s_q, s_d, r_q, r_d;
   logic             done_q, done_d, err_q, err_d;
   logic             busy_q, busy_d, ready_q, ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         tgt_q     <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         tgt_q     <= tgt_d;
         s_q       <= s_d;
         r_q       <= r_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      tgt_d   = tgt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               tgt_d   = req_set;
               timer_d = PULSE_LD;
               state_d = PULSE;
            end
         end
         PULSE: begin
            if (timer_q == '0) begin
               timer_d = GAP_LD;
               state_d = GAP;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               timer_d = TO_LD;
               state_d = CHECK;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         CHECK: begin
            if (q_fb == tgt_q || timer_q == '0) state_d = IDLE;
            else                                timer_d = timer_q - ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // S and R come from one target bit, so they can never be high together.
   always_comb begin
      s_d       = (state_d == PULSE) &&  tgt_d;
      r_d       = (state_d == PULSE) && !tgt_d;
      done_d    = (state_q == CHECK) && (q_fb == tgt_q);
      err_d     = (state_q == CHECK) && (q_fb != tgt_q) && (timer_q == '0);
      busy_d    = (state_d != IDLE);
      ready_d   = (state_d == IDLE);
      err_cnt_d = err_cnt_q;
      if (err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE;
   end

   assign S         = s_q;
   assign R         = r_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign req_ready = ready_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Scoreboard bench for sr_cmd_driver: a behavioural SR latch closes the loop,
// expected completions are queued at issue time and matched as done/err appear.
module tb_sr_cmd_driver;
   localparam int P = 2, G = 1, T = 4, W = 8;
   localparam int LAT_OK = P + G + 1;
   localparam int LAT_TO = P + G + T;
   localparam int DLY = 5;
   localparam int LAT_LATE = DLY + 1;
   localparam int P2 = 1, G2 = 2, T2 = 1;
   localparam int LAT2_TO = P2 + G2 + T2;

   typedef struct {
      logic is_err;
      int   at_edge;
      logic tgt;
      logic chk_q;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0, req_set = 1'b0;
   logic req_ready, S, R, busy, done, err, q_fb;
   logic [W-1:0] err_cnt;
   logic [1:0] fb_mode = 2'd0;
   logic q_latch = 1'b0;
   logic [DLY-1:0] dly_q = '0;

   logic req_valid2 = 1'b0;
   logic req_ready2, S2, R2, busy2, done2, err2;
   logic [W-1:0] err_cnt2;

   int edge_n = 0, rst_edges = 0;
   int n_chk = 0, n_pass = 0, n_done = 0;
   int exp_cnt = 0, hi_cnt = 0, lo_cnt = 100, pulse_rst = 0;
   bit started = 1'b0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   always @(S or R) q_latch = S ? 1'b1 : (R ? 1'b0 : q_latch);
   always @(posedge clk) dly_q <= {dly_q[DLY-2:0], q_latch};
   always @(posedge clk) edge_n <= edge_n + 1;
   always @(posedge clk) if (rst) rst_edges <= rst_edges + 1;
   assign q_fb = (fb_mode == 2'd0) ? q_latch : (fb_mode == 2'd1) ? 1'b0 : dly_q[DLY-1];

   sr_cmd_driver #(.PULSE_W(P), .GAP_W(G), .TIMEOUT(T), .CNT_W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_ready(req_ready),
      .S(S), .R(R), .q_fb(q_fb), .busy(busy), .done(done), .err(err), .err_cnt(err_cnt));

   sr_cmd_driver #(.PULSE_W(P2), .GAP_W(G2), .TIMEOUT(T2), .CNT_W(W)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid2), .req_set(1'b1), .req_ready(req_ready2),
      .S(S2), .R(R2), .q_fb(1'b0), .busy(busy2), .done(done2), .err(err2), .err_cnt(err_cnt2));

   task automatic chk(input string tag, input int got, input int exp_v);
      n_chk++;
      if (got == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp_v, edge_n);
   endtask

   task automatic mon();
      exp_t e;
      if (!started) return;
      if (rst) exp_cnt = 0;
      chk("s_and_r", int'(S & R), 0);
      chk("done_and_err", int'(done & err), 0);
      chk("busy_vs_ready", int'(busy), int'(!req_ready));
      if (done || err) begin
         if (done) n_done++;
         if (sbq.size() == 0) begin
            chk("spurious_out", int'({done, err}), 0);
         end else begin
            e = sbq.pop_front();
            chk("kind_err", int'(err), int'(e.is_err));
            chk("latency_edge", edge_n, e.at_edge);
            chk("ready_at_out", int'(req_ready), 1);
            if (e.is_err && exp_cnt != 255) exp_cnt++;
            chk("err_cnt", int'(err_cnt), exp_cnt);
            if (e.chk_q) chk("q_final", int'(q_latch), int'(e.tgt));
         end
      end
      if (S || R) begin
         if (hi_cnt == 0) begin
            chk("gap_before_pulse", int'(lo_cnt >= G), 1);
            pulse_rst = rst_edges;
         end
         hi_cnt++;
         lo_cnt = 0;
      end else begin
         if (hi_cnt != 0 && pulse_rst == rst_edges) chk("pulse_width", hi_cnt, P);
         hi_cnt = 0;
         lo_cnt++;
      end
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic send(input logic set, input logic is_err, input int lat,
                       input logic hold, input logic push);
      int k = 0;
      while (req_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("ready_timeout", k, 0);
      req_set   = set;
      req_valid = 1'b1;
      if (push) sbq.push_back('{is_err, edge_n + 1 + lat, set, fb_mode == 2'd0});
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sbq.size() != 0 && k < 200) begin @(negedge clk); k++; end
      if (sbq.size() != 0) begin
         chk("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic main_seq();
      int a, k, d0;
      repeat (2) @(negedge clk);
      started = 1'b1;
      chk("rst_S", int'(S), 0);
      chk("rst_R", int'(R), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_err_cnt", int'(err_cnt), 0);
      chk("rst2_ready", int'(req_ready2), 1);
      rst = 1'b0;
      @(negedge clk);

      send(1'b1, 1'b0, LAT_OK, 1'b0, 1'b1);
      chk("set_S_cycle1", int'(S), 1);
      chk("set_R_cycle1", int'(R), 0);
      chk("set_busy", int'(busy), 1);
      drain();
      send(1'b0, 1'b0, LAT_OK, 1'b0, 1'b1);
      drain();
      send(1'b0, 1'b0, LAT_OK, 1'b0, 1'b1);
      drain();

      d0 = n_done;
      send(1'b1, 1'b0, LAT_OK, 1'b1, 1'b1);
      send(1'b0, 1'b0, LAT_OK, 1'b1, 1'b1);
      send(1'b1, 1'b0, LAT_OK, 1'b0, 1'b1);
      drain();
      chk("b2b_done_pulses", n_done - d0, 3);

      send(1'b0, 1'b0, LAT_OK, 1'b0, 1'b1);
      drain();
      send(1'b1, 1'b0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_S", int'(S), 0);
      chk("midrst_ready", int'(req_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_err_cnt", int'(err_cnt), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      send(1'b0, 1'b0, LAT_OK, 1'b0, 1'b1);
      drain();

      repeat (DLY + 2) @(negedge clk);
      fb_mode = 2'd2;
      send(1'b1, 1'b0, LAT_LATE, 1'b0, 1'b1);
      drain();

      fb_mode = 2'd1;
      for (int i = 0; i < 257; i++) send(1'b1, 1'b1, LAT_TO, 1'b0, 1'b1);
      drain();
      chk("err_cnt_saturated", int'(err_cnt), 255);
      fb_mode = 2'd0;

      a = edge_n + 1;
      req_valid2 = 1'b1;
      @(negedge clk);
      req_valid2 = 1'b0;
      k = 0;
      while (!(done2 || err2) && k < 20) begin @(negedge clk); k++; end
      chk("i2_err", int'(err2), 1);
      chk("i2_done", int'(done2), 0);
      chk("i2_latency_edge", edge_n, a + LAT2_TO);
      chk("i2_err_cnt", int'(err_cnt2), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      fork
         forever begin @(negedge clk); mon(); end
         main_seq();
      join_any
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
